// File: rtl/mux5_rr_arbiter_if.sv
// Requester/consumer bundle for the five-way round-robin mux arbiter.
// master = requester/consumer side, slave = arbiter side.
interface mux5_rr_arbiter_if #(
  parameter int W = 8
);
  logic [4:0]     req;
  logic [5*W-1:0] din;
  logic [4:0]     gnt;
  logic [2:0]     sel;
  logic [W-1:0]   dout;
  logic           dout_vld;
  logic           busy;

  modport master (output req, din, input gnt, sel, dout, dout_vld, busy);
  modport slave  (input req, din, output gnt, sel, dout, dout_vld, busy);
endinterface

// File: rtl/mux5_rr_arbiter.sv
// Round-robin arbiter/sequencer for a shared 5:1 select datapath with registered data output.
// Optional macro MUX5_ARB_BURST_EN: force holder release after MAX_BURST contended grant cycles.
module mux5_rr_arbiter #(
  parameter int W         = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mux5_rr_arbiter_if.slave  bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_max_burst_range
    $error("MAX_BURST must be within 1..15");
  end

  function automatic logic [2:0] wrap_inc(input logic [2:0] k);
    return (k == 3'd4) ? 3'd0 : k + 3'd1;
  endfunction

  // Datapath select encoding: s[2] picks input 4, s[1:0] pick inputs 0-3.
  function automatic logic [2:0] sel_enc(input logic [2:0] k);
    return (k == 3'd4) ? 3'b100 : {1'b0, k[1:0]};
  endfunction

  // Returns {hit, index} of the first request found searching from start upward mod 5.
  function automatic logic [3:0] rr_pick(input logic [4:0] r, input logic [2:0] start);
    logic [2:0] k;
    logic       hit;
    logic [2:0] win;
    k   = start;
    hit = 1'b0;
    win = 3'd0;
    for (int i = 0; i < 5; i++) begin
      if (!hit && r[k]) begin
        hit = 1'b1;
        win = k;
      end
      k = wrap_inc(k);
    end
    return {hit, win};
  endfunction

  logic [0:0]   state_q, state_d;
  logic [4:0]   gnt_q, gnt_d;
  logic [2:0]   sel_q, sel_d;
  logic [2:0]   ptr_q, ptr_d;
  logic [W-1:0] dout_q, dout_d;
  logic         vld_q, vld_d;

  logic [2:0]   hold_idx;
  logic [W-1:0] hold_data;
  logic         hold_req;
  logic         force_rel;
  logic         new_grant;
  logic [3:0]   pick;

  always_comb begin
    hold_idx  = 3'd0;
    hold_data = '0;
    for (int k = 0; k < 5; k++) begin
      if (gnt_q[k]) begin
        hold_idx  = 3'(k);
        hold_data = bus.din[k*W +: W];
      end
    end
  end

  assign hold_req = |(gnt_q & bus.req);

`ifdef MUX5_ARB_BURST_EN
  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  logic [3:0] cnt_q, cnt_d;

  // Only a contended holder is pushed out; an uncontended one just restarts its count.
  assign force_rel = (state_q == ST_GRANT) && (cnt_q == BURST_LAST) && |(bus.req & ~gnt_q);

  always_comb begin
    cnt_d = 4'd0;
    if (state_d == ST_GRANT && !new_grant && cnt_q != BURST_LAST) cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 4'd0;
    else        cnt_q <= cnt_d;
  end
`else
  assign force_rel = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    new_grant = 1'b0;
    pick      = 4'd0;
    case (state_q)
      ST_IDLE: begin
        pick = rr_pick(bus.req, ptr_q);
        if (pick[3]) begin
          gnt_d     = 5'(5'b00001 << pick[2:0]);
          sel_d     = sel_enc(pick[2:0]);
          state_d   = ST_GRANT;
          new_grant = 1'b1;
        end
      end
      ST_GRANT: begin
        // Release hands over on the same edge; the old holder is masked out of the search.
        if (!hold_req || force_rel) begin
          ptr_d = wrap_inc(hold_idx);
          pick  = rr_pick(bus.req & ~gnt_q, wrap_inc(hold_idx));
          if (pick[3]) begin
            gnt_d     = 5'(5'b00001 << pick[2:0]);
            sel_d     = sel_enc(pick[2:0]);
            new_grant = 1'b1;
          end else begin
            gnt_d   = 5'd0;
            sel_d   = 3'b000;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        gnt_d   = 5'd0;
        sel_d   = 3'b000;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign vld_d  = hold_req;
  assign dout_d = hold_req ? hold_data : dout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= 5'd0;
      sel_q   <= 3'b000;
      ptr_q   <= 3'd0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.sel      = sel_q;
  assign bus.busy     = |gnt_q;
  assign bus.dout     = dout_q;
  assign bus.dout_vld = vld_q;

endmodule

// File: tb/tb_mux5_rr_arbiter.sv
// Directed self-checking bench for mux5_rr_arbiter (default build and MUX5_ARB_BURST_EN build).
module tb_mux5_rr_arbiter;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  mux5_rr_arbiter_if #(.W(W)) bus ();

  mux5_rr_arbiter #(.W(W), .MAX_BURST(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = 5'd0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.req = 5'd0;
    bus.din = '0;
    #3;
    n_checks++; if (bus.gnt !== 5'd0) begin n_fail++; $display("FAIL por_gnt got=%b exp=%b", bus.gnt, 5'd0); end
    n_checks++; if (bus.sel !== 3'd0) begin n_fail++; $display("FAIL por_sel got=%b exp=%b", bus.sel, 3'd0); end
    n_checks++; if (bus.dout_vld !== 1'b0) begin n_fail++; $display("FAIL por_vld got=%b exp=0", bus.dout_vld); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL por_busy got=%b exp=0", bus.busy); end
    tick();
    rst_n = 1'b1;
    bus.req = 5'b00100;
    bus.din[2*W +: W] = 8'h3C;
    tick();
    n_checks++; if (bus.gnt !== 5'b00100) begin n_fail++; $display("FAIL mid_gnt got=%b exp=%b", bus.gnt, 5'b00100); end
    tick();
    n_checks++; if (bus.dout !== 8'h3C || bus.dout_vld !== 1'b1) begin n_fail++; $display("FAIL mid_data got=%h/%b exp=3c/1", bus.dout, bus.dout_vld); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.gnt !== 5'd0) begin n_fail++; $display("FAIL arst_gnt got=%b exp=%b", bus.gnt, 5'd0); end
    n_checks++; if (bus.sel !== 3'd0) begin n_fail++; $display("FAIL arst_sel got=%b exp=%b", bus.sel, 3'd0); end
    n_checks++; if (bus.dout !== 8'h00) begin n_fail++; $display("FAIL arst_dout got=%h exp=00", bus.dout); end
    n_checks++; if (bus.dout_vld !== 1'b0) begin n_fail++; $display("FAIL arst_vld got=%b exp=0", bus.dout_vld); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy got=%b exp=0", bus.busy); end
    tick();
    bus.req = 5'd0;
    rst_n = 1'b1;
    tick();
    n_checks++; if (bus.gnt !== 5'd0 || bus.dout_vld !== 1'b0) begin n_fail++; $display("FAIL post_rst_idle got=%b/%b exp=00000/0", bus.gnt, bus.dout_vld); end
  endtask

  task automatic test_single();
    do_reset();
    bus.req = 5'b10000;
    bus.din[4*W +: W] = 8'hA5;
    tick();
    n_checks++; if (bus.gnt !== 5'b10000) begin n_fail++; $display("FAIL single_gnt got=%b exp=%b", bus.gnt, 5'b10000); end
    n_checks++; if (bus.sel !== 3'b100) begin n_fail++; $display("FAIL single_sel got=%b exp=%b", bus.sel, 3'b100); end
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got=%b exp=1", bus.busy); end
    n_checks++; if (bus.dout_vld !== 1'b0) begin n_fail++; $display("FAIL single_lat got=%b exp=0", bus.dout_vld); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (bus.dout !== 8'hA5 || bus.dout_vld !== 1'b1) begin n_fail++; $display("FAIL single_word%0d got=%h/%b exp=a5/1", i, bus.dout, bus.dout_vld); end
    end
    bus.req = 5'd0;
    tick();
    n_checks++; if (bus.gnt !== 5'd0 || bus.sel !== 3'd0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_release got=%b/%b/%b exp=00000/000/0", bus.gnt, bus.sel, bus.busy); end
    n_checks++; if (bus.dout !== 8'hA5 || bus.dout_vld !== 1'b0) begin n_fail++; $display("FAIL single_hold got=%h/%b exp=a5/0", bus.dout, bus.dout_vld); end
  endtask

  task automatic test_round_robin();
    logic [4:0] gnt_exp [6];
    logic [2:0] sel_exp [6];
    logic [7:0] dat_exp [6];
    gnt_exp = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
    sel_exp = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b000};
    dat_exp = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h10};
    do_reset();
    bus.din = {8'h14, 8'h13, 8'h12, 8'h11, 8'h10};
    bus.req = 5'b11111;
    tick();
    for (int i = 0; i < 6; i++) begin
      n_checks++; if (bus.gnt !== gnt_exp[i] || bus.sel !== sel_exp[i]) begin n_fail++; $display("FAIL rr_grant%0d got=%b/%b exp=%b/%b", i, bus.gnt, bus.sel, gnt_exp[i], sel_exp[i]); end
      n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rr_busy%0d got=%b exp=1", i, bus.busy); end
      bus.req = 5'b11111;
      tick();
      n_checks++; if (bus.dout !== dat_exp[i] || bus.dout_vld !== 1'b1) begin n_fail++; $display("FAIL rr_w1_%0d got=%h/%b exp=%h/1", i, bus.dout, bus.dout_vld, dat_exp[i]); end
      tick();
      n_checks++; if (bus.dout !== dat_exp[i] || bus.dout_vld !== 1'b1) begin n_fail++; $display("FAIL rr_w2_%0d got=%h/%b exp=%h/1", i, bus.dout, bus.dout_vld, dat_exp[i]); end
      if (i < 5) begin
        bus.req = 5'b11111 & ~gnt_exp[i];
        tick();
        n_checks++; if (bus.dout_vld !== 1'b0) begin n_fail++; $display("FAIL rr_gap%0d got=%b exp=0", i, bus.dout_vld); end
      end
    end
    bus.req = 5'd0;
    tick();
    n_checks++; if (bus.gnt !== 5'd0) begin n_fail++; $display("FAIL rr_idle got=%b exp=00000", bus.gnt); end
  endtask

  task automatic test_handover_exclusion();
    do_reset();
    bus.din = {8'h44, 8'h33, 8'h22, 8'h11, 8'h00};
    bus.req = 5'b00100;
    tick();
    n_checks++; if (bus.gnt !== 5'b00100) begin n_fail++; $display("FAIL ho_first got=%b exp=%b", bus.gnt, 5'b00100); end
    bus.req = 5'b00101;
    tick();
    n_checks++; if (bus.gnt !== 5'b00100 || bus.dout !== 8'h22) begin n_fail++; $display("FAIL ho_nopreempt got=%b/%h exp=00100/22", bus.gnt, bus.dout); end
    bus.req = 5'b00001;
    tick();
    n_checks++; if (bus.gnt !== 5'b00001 || bus.sel !== 3'b000) begin n_fail++; $display("FAIL ho_wrap got=%b/%b exp=00001/000", bus.gnt, bus.sel); end
    bus.req = 5'b00101;
    tick();
    n_checks++; if (bus.gnt !== 5'b00001 || bus.dout !== 8'h00 || bus.dout_vld !== 1'b1) begin n_fail++; $display("FAIL ho_keep got=%b/%h/%b exp=00001/00/1", bus.gnt, bus.dout, bus.dout_vld); end
    // Holder 0 drops with ptr now 1: requests 2 and 3 pending, 2 is nearest.
    bus.req = 5'b01100;
    tick();
    n_checks++; if (bus.gnt !== 5'b00100 || bus.sel !== 3'b010) begin n_fail++; $display("FAIL ho_next got=%b/%b exp=00100/010", bus.gnt, bus.sel); end
    bus.req = 5'b01000;
    tick();
    n_checks++; if (bus.gnt !== 5'b01000 || bus.sel !== 3'b011) begin n_fail++; $display("FAIL ho_next2 got=%b/%b exp=01000/011", bus.gnt, bus.sel); end
    bus.req = 5'd0;
    tick();
  endtask

  task automatic test_burst();
    logic [4:0] gnt_exp [13];
    logic [7:0] dat_exp [13];
`ifdef MUX5_ARB_BURST_EN
    gnt_exp = '{5'b00000, 5'b00010, 5'b00010, 5'b00010, 5'b00010, 5'b01000, 5'b01000,
                5'b01000, 5'b01000, 5'b00010, 5'b00010, 5'b00010, 5'b00010};
    dat_exp = '{8'h00, 8'h00, 8'hB1, 8'hB1, 8'hB1, 8'hB1, 8'hD3,
                8'hD3, 8'hD3, 8'hD3, 8'hB1, 8'hB1, 8'hB1};
`else
    gnt_exp = '{5'b00000, 5'b00010, 5'b00010, 5'b00010, 5'b00010, 5'b00010, 5'b00010,
                5'b00010, 5'b00010, 5'b00010, 5'b00010, 5'b00010, 5'b00010};
    dat_exp = '{8'h00, 8'h00, 8'hB1, 8'hB1, 8'hB1, 8'hB1, 8'hB1,
                8'hB1, 8'hB1, 8'hB1, 8'hB1, 8'hB1, 8'hB1};
`endif
    do_reset();
    bus.din = {8'h00, 8'hD3, 8'h00, 8'hB1, 8'h00};
    bus.req = 5'b01010;
    for (int i = 1; i <= 12; i++) begin
      tick();
      n_checks++; if (bus.gnt !== gnt_exp[i]) begin n_fail++; $display("FAIL burst_gnt_e%0d got=%b exp=%b", i, bus.gnt, gnt_exp[i]); end
      if (i >= 2) begin
        n_checks++; if (bus.dout !== dat_exp[i] || bus.dout_vld !== 1'b1) begin n_fail++; $display("FAIL burst_dat_e%0d got=%h/%b exp=%h/1", i, bus.dout, bus.dout_vld, dat_exp[i]); end
      end
    end
    bus.req = 5'b00010;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++; if (bus.gnt !== 5'b00010 || bus.sel !== 3'b001) begin n_fail++; $display("FAIL solo_hold%0d got=%b/%b exp=00010/001", i, bus.gnt, bus.sel); end
      n_checks++; if (bus.dout !== 8'hB1 || bus.dout_vld !== 1'b1) begin n_fail++; $display("FAIL solo_dat%0d got=%h/%b exp=b1/1", i, bus.dout, bus.dout_vld); end
    end
    bus.req = 5'd0;
    tick();
    n_checks++; if (bus.gnt !== 5'd0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL burst_idle got=%b/%b exp=00000/0", bus.gnt, bus.busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_handover_exclusion();
    test_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
